// File: rtl/seg7_scanner.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scanner
// Description : Eight-digit multiplexed seven-segment display scanner.
//               A prescaler divides each digit slot into REFRESH_DIV cycles.
//               The first GUARD cycles of every slot keep all anodes and
//               cathodes off so the previous digit cannot ghost into the next.
//               Digit codes, decimal points and enables are snapshotted once
//               per frame (on the last tick of digit 7). The display therefore
//               never tears mid-frame. All outputs are registered, with one
//               cycle of latency from the scan state.
//
// Ports       : CLK            system clock, rising edge
//               RST            synchronous active-high reset
//               DIGITS[31:0]   eight 4-bit codes, DIGITS[4k+3:4k] = digit k
//                              (digit 0 is rightmost)
//               DP_IN[7:0]     decimal point request per digit (active-high)
//               EN_MASK[7:0]   digit enable per digit (0 = anode off)
//               CA..CG, DP     segment / decimal-point cathodes (active-low)
//               AN0..AN7       digit anodes (active-low)
//               FRAME          one-cycle pulse when a new snapshot is loaded
//
// Config      : SEG7_HEX_DECODE_EN - when defined, codes 10..15 show A,b,C,d,E,F.
//                                    When undefined, those codes are blank.
//
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scanner #(
    parameter int REFRESH_DIV = 100000,
    parameter int GUARD       = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] DIGITS,
    input  logic [7:0]  DP_IN,
    input  logic [7:0]  EN_MASK,
    output logic        CA,
    output logic        CB,
    output logic        CC,
    output logic        CD,
    output logic        CE,
    output logic        CF,
    output logic        CG,
    output logic        DP,
    output logic        AN0,
    output logic        AN1,
    output logic        AN2,
    output logic        AN3,
    output logic        AN4,
    output logic        AN5,
    output logic        AN6,
    output logic        AN7,
    output logic        FRAME
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] C_P_LAST = PW'(REFRESH_DIV - 1);

    // Scan state
    logic [PW-1:0] r_p;
    logic [2:0]    r_idx;

    // Per-frame snapshot of the inputs
    logic [31:0]   r_sh_digits;
    logic [7:0]    r_sh_dp;
    logic [7:0]    r_sh_en;

    // Registered outputs
    logic [7:0]    r_an;
    logic [6:0]    r_seg;     // {CG..CA}
    logic          r_dp;
    logic          r_frame;

    // Combinational next-output values
    logic          w_tick;
    logic          w_last_tick;
    logic          w_in_guard;
    logic [3:0]    w_code;
    logic          w_cur_en;
    logic          w_cur_dp;
    logic [6:0]    w_decoded;
    logic [7:0]    w_an_next;
    logic [6:0]    w_seg_next;
    logic          w_dp_next;

    // Segment decode, active-low, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] seg;
        case (code)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
`ifdef SEG7_HEX_DECODE_EN
            4'd10:   seg = 7'b0001000;
            4'd11:   seg = 7'b0000011;
            4'd12:   seg = 7'b1000110;
            4'd13:   seg = 7'b0100001;
            4'd14:   seg = 7'b0000110;
            default: seg = 7'b0001110;
`else
            default: seg = 7'b1111111;
`endif
        endcase
        return seg;
    endfunction

    assign w_tick      = (r_p == C_P_LAST);
    assign w_last_tick = w_tick && (r_idx == 3'd7);

    // The comparison is done in int so that GUARD = 0 yields a plain
    // "never in guard" rather than an unsigned constant comparison.
    assign w_in_guard  = (int'(r_p) < GUARD);

    assign w_code      = r_sh_digits[{r_idx, 2'b00} +: 4];
    assign w_cur_en    = r_sh_en[r_idx];
    assign w_cur_dp    = r_sh_dp[r_idx];
    assign w_decoded   = decode(w_code);

    always_comb begin
        w_an_next  = 8'hFF;
        w_seg_next = 7'h7F;
        w_dp_next  = 1'b1;
        if (!w_in_guard && w_cur_en) begin
            // Only the current digit can be driven, so at most one anode is low
            w_an_next  = ~(8'b0000_0001 << r_idx);
            w_seg_next = w_decoded;
            w_dp_next  = ~w_cur_dp;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_p         <= '0;
            r_idx       <= 3'd0;
            r_sh_digits <= 32'd0;
            r_sh_dp     <= 8'd0;
            r_sh_en     <= 8'd0;
            r_an        <= 8'hFF;
            r_seg       <= 7'h7F;
            r_dp        <= 1'b1;
            r_frame     <= 1'b0;
        end else begin
            r_p <= w_tick ? '0 : r_p + 1'b1;
            if (w_tick) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_last_tick) begin
                r_sh_digits <= DIGITS;
                r_sh_dp     <= DP_IN;
                r_sh_en     <= EN_MASK;
            end
            r_frame <= w_last_tick;
            r_an    <= w_an_next;
            r_seg   <= w_seg_next;
            r_dp    <= w_dp_next;
        end
    end

    assign CA    = r_seg[0];
    assign CB    = r_seg[1];
    assign CC    = r_seg[2];
    assign CD    = r_seg[3];
    assign CE    = r_seg[4];
    assign CF    = r_seg[5];
    assign CG    = r_seg[6];
    assign DP    = r_dp;
    assign AN0   = r_an[0];
    assign AN1   = r_an[1];
    assign AN2   = r_an[2];
    assign AN3   = r_an[3];
    assign AN4   = r_an[4];
    assign AN5   = r_an[5];
    assign AN6   = r_an[6];
    assign AN7   = r_an[7];
    assign FRAME = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scanner
// Description : Testbench for seg7_scanner with REFRESH_DIV=8 and GUARD=2.
//               A cycle-count reference model predicts every output in
//               every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scanner;

    localparam int RD        = 8;
    localparam int GD        = 2;
    localparam int FRAME_LEN = 8 * RD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] digits  = 32'd0;
    logic [7:0]  dp_in   = 8'd0;
    logic [7:0]  en_mask = 8'd0;

    logic ca, cb, cc, cd, ce, cf, cg, dp;
    logic an0, an1, an2, an3, an4, an5, an6, an7;
    logic frame;

    seg7_scanner #(
        .REFRESH_DIV (RD),
        .GUARD       (GD)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .DIGITS  (digits),
        .DP_IN   (dp_in),
        .EN_MASK (en_mask),
        .CA      (ca),
        .CB      (cb),
        .CC      (cc),
        .CD      (cd),
        .CE      (ce),
        .CF      (cf),
        .CG      (cg),
        .DP      (dp),
        .AN0     (an0),
        .AN1     (an1),
        .AN2     (an2),
        .AN3     (an3),
        .AN4     (an4),
        .AN5     (an5),
        .AN6     (an6),
        .AN7     (an7),
        .FRAME   (frame)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: cycles since reset release and the frame snapshot
    int          m_n = 0;
    logic [31:0] m_dig = 32'd0;
    logic [7:0]  m_dp  = 8'd0;
    logic [7:0]  m_en  = 8'd0;
    int          cyc = 0;
    int          last_frame = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] c);
        logic [6:0] s;
        case (c)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
`ifdef SEG7_HEX_DECODE_EN
            4'd10:   s = 7'b0001000;
            4'd11:   s = 7'b0000011;
            4'd12:   s = 7'b1000110;
            4'd13:   s = 7'b0100001;
            4'd14:   s = 7'b0000110;
            default: s = 7'b0001110;
`else
            default: s = 7'b1111111;
`endif
        endcase
        return s;
    endfunction

    // One clock cycle: predict the outputs produced by this edge, advance the
    // model, clock the DUT and compare.
    task automatic step();
        int          slot_pos;
        int          k;
        logic [7:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp;
        logic        e_frame;
        logic [7:0]  g_an;
        logic [6:0]  g_seg;
        logic        was_rst;

        slot_pos = m_n % RD;
        k        = (m_n / RD) % 8;
        e_an     = 8'hFF;
        e_seg    = 7'h7F;
        e_dp     = 1'b1;
        e_frame  = 1'b0;
        was_rst  = rst;

        if (rst) begin
            m_n   = 0;
            m_dig = 32'd0;
            m_dp  = 8'd0;
            m_en  = 8'd0;
        end else begin
            if (slot_pos >= GD && m_en[k]) begin
                e_an     = 8'hFF;
                e_an[k]  = 1'b0;
                e_seg    = seg_of(m_dig[4*k +: 4]);
                e_dp     = ~m_dp[k];
            end
            if (m_n == FRAME_LEN - 1) begin
                e_frame = 1'b1;
                m_dig   = digits;
                m_dp    = dp_in;
                m_en    = en_mask;
            end
            m_n = (m_n + 1) % FRAME_LEN;
        end

        @(posedge clk);
        #1;
        cyc++;

        g_an  = {an7, an6, an5, an4, an3, an2, an1, an0};
        g_seg = {cg, cf, ce, cd, cc, cb, ca};
        check("anodes",   32'(g_an),  32'(e_an));
        check("segments", 32'(g_seg), 32'(e_seg));
        check("dp",       32'(dp),    32'(e_dp));
        check("frame",    32'(frame), 32'(e_frame));
        check("one_anode", 32'($countones(~g_an) <= 1), 32'd1);

        if (was_rst) begin
            last_frame = cyc;
        end else if (frame) begin
            check("frame_period", 32'(cyc - last_frame), 32'(FRAME_LEN));
            last_frame = cyc;
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
        end
    endtask

    initial begin
        // Reset held for a few cycles
        rst = 1'b1;
        run(3);

        // Counting pattern, all digits enabled
        rst     = 1'b0;
        digits  = 32'h7654_3210;
        en_mask = 8'hFF;
        dp_in   = 8'h00;
        run(3 * FRAME_LEN);

        // Mid-frame change must not appear before the next snapshot
        digits  = 32'h0000_0005;
        en_mask = 8'h01;
        run(FRAME_LEN + 20);
        digits  = 32'h0000_0009;
        run(2 * FRAME_LEN);

        // Single digit enabled with decimal point
        dp_in   = 8'h01;
        run(2 * FRAME_LEN);

        // Hex code on digit 0
        digits  = 32'h0000_000A;
        dp_in   = 8'h00;
        run(2 * FRAME_LEN);

        // One-cycle reset in the middle of digit 3's lit window
        digits  = 32'h1234_5678;
        en_mask = 8'hFF;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (m_n == 3 * RD + 4) break;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        run(3 * FRAME_LEN);

        // Random inputs with occasional reset pulses
        for (int it = 0; it < 30; it++) begin
            digits  = $urandom;
            dp_in   = 8'($urandom);
            en_mask = 8'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 3));
                rst = 1'b0;
            end
            run($urandom_range(1, 100));
        end
        run(2 * FRAME_LEN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
